// File: rtl/execute_feedback_arbiter_pkg.sv
// Shared constants and types for the execute feedback arbiter.
// Defines the requester count (sum of execute unit counts), the write-port
// count, the feedback request bundle and a pointer-width helper.
package execute_feedback_arbiter_pkg;

    localparam int ALU_UNIT_NUM = 2;
    localparam int BRU_UNIT_NUM = 1;
    localparam int CSR_UNIT_NUM = 1;
    localparam int DIV_UNIT_NUM = 1;
    localparam int LSU_UNIT_NUM = 2;
    localparam int MUL_UNIT_NUM = 1;

    localparam int EXECUTE_FEEDBACK_REQ_NUM =
        ALU_UNIT_NUM + BRU_UNIT_NUM + CSR_UNIT_NUM +
        DIV_UNIT_NUM + LSU_UNIT_NUM + MUL_UNIT_NUM;

    localparam int EXECUTE_FEEDBACK_PORT_NUM = 2;

    localparam int PHY_REG_ID_WIDTH_DEF = 6;
    localparam int DATA_WIDTH_DEF       = 32;

    // One requester's feedback bundle at the default widths.
    typedef struct packed {
        logic                            enable;
        logic [PHY_REG_ID_WIDTH_DEF-1:0] phy_id;
        logic [DATA_WIDTH_DEF-1:0]       value;
    } feedback_req_t;

    // Round-robin pointer width; at least one bit so a single
    // requester still has a legal vector.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/execute_feedback_arbiter_rr_multi_grant_picker.sv
// Combinational round-robin picker granting up to PORT_NUM requesters.
// Ports: req_i request vector, ptr_i priority pointer; grant_o per-port
// one-hot grant (port p at [p*REQ_NUM +: REQ_NUM]), valid_o per-port
// valid, next_ptr_o index after the last granted requester.
module execute_feedback_arbiter_rr_multi_grant_picker
    import execute_feedback_arbiter_pkg::*;
#(
    parameter int REQ_NUM  = EXECUTE_FEEDBACK_REQ_NUM,
    parameter int PORT_NUM = EXECUTE_FEEDBACK_PORT_NUM,
    parameter int PTR_W    = ptr_width(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0]          req_i,
    input  logic [PTR_W-1:0]            ptr_i,
    output logic [PORT_NUM*REQ_NUM-1:0] grant_o,
    output logic [PORT_NUM-1:0]         valid_o,
    output logic [PTR_W-1:0]            next_ptr_o
);

    localparam int CNT_W = $clog2(PORT_NUM + 1);
    localparam logic [PTR_W:0] REQ_L = (PTR_W+1)'(REQ_NUM);
    localparam logic [CNT_W-1:0] PORT_L = CNT_W'(PORT_NUM);

    logic [CNT_W-1:0] cnt;
    logic [PTR_W:0]   idx;
    logic [PTR_W:0]   nxt;

    // Walk requesters from ptr_i upward with wrap; the k-th hit
    // lands on port k until every port is used.
    always_comb begin
        grant_o    = '0;
        valid_o    = '0;
        next_ptr_o = ptr_i;
        cnt        = '0;
        idx        = '0;
        nxt        = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            idx = {1'b0, ptr_i} + (PTR_W+1)'(i);
            if (idx >= REQ_L) begin
                idx = idx - REQ_L;
            end
            if (req_i[idx[PTR_W-1:0]] && (cnt < PORT_L)) begin
                grant_o[int'(cnt)*REQ_NUM + int'(idx)] = 1'b1;
                valid_o[cnt] = 1'b1;
                cnt = cnt + 1'b1;
                nxt = idx + 1'b1;
                if (nxt == REQ_L) begin
                    nxt = '0;
                end
                next_ptr_o = nxt[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/execute_feedback_arbiter.sv
// Round-robin arbiter sharing register-file write/wakeup ports among
// execute feedback requesters; grants are combinational, port outputs
// registered one cycle later.
// Ports: clk, rst (sync, active-high), flush, req_valid/req_phy_id/
// req_value in, req_ready out, port_valid/port_phy_id/port_value out.
// Optional EXECUTE_FEEDBACK_ARBITER_PERF_EN adds perf_grant_count and
// perf_conflict_count outputs.
module execute_feedback_arbiter
    import execute_feedback_arbiter_pkg::*;
#(
    parameter int REQ_NUM          = EXECUTE_FEEDBACK_REQ_NUM,
    parameter int PORT_NUM         = EXECUTE_FEEDBACK_PORT_NUM,
    parameter int PHY_REG_ID_WIDTH = PHY_REG_ID_WIDTH_DEF,
    parameter int DATA_WIDTH       = DATA_WIDTH_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic [REQ_NUM-1:0]                   req_valid,
    input  logic [REQ_NUM*PHY_REG_ID_WIDTH-1:0]  req_phy_id,
    input  logic [REQ_NUM*DATA_WIDTH-1:0]        req_value,
    output logic [REQ_NUM-1:0]                   req_ready,
    output logic [PORT_NUM-1:0]                  port_valid,
    output logic [PORT_NUM*PHY_REG_ID_WIDTH-1:0] port_phy_id,
    output logic [PORT_NUM*DATA_WIDTH-1:0]       port_value
`ifdef EXECUTE_FEEDBACK_ARBITER_PERF_EN
    ,
    output logic [31:0]                          perf_grant_count,
    output logic [31:0]                          perf_conflict_count
`endif
);

    localparam int PTR_W = ptr_width(REQ_NUM);
    localparam int IDW   = PHY_REG_ID_WIDTH;
    localparam int DW    = DATA_WIDTH;

    logic [PTR_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [PORT_NUM-1:0]         port_valid_q, port_valid_d;
    logic [PORT_NUM*IDW-1:0]     port_id_q, port_id_d;
    logic [PORT_NUM*DW-1:0]      port_val_q, port_val_d;

    logic [PORT_NUM*REQ_NUM-1:0] pick_grant;
    logic [PORT_NUM-1:0]         pick_valid;
    logic [PTR_W-1:0]            pick_next;
    logic [REQ_NUM-1:0]          grant_any;
    logic [PORT_NUM*IDW-1:0]     mux_id;
    logic [PORT_NUM*DW-1:0]      mux_val;
    logic                        live;

    execute_feedback_arbiter_rr_multi_grant_picker #(
        .REQ_NUM  (REQ_NUM),
        .PORT_NUM (PORT_NUM),
        .PTR_W    (PTR_W)
    ) u_picker (
        .req_i      (req_valid),
        .ptr_i      (rr_ptr_q),
        .grant_o    (pick_grant),
        .valid_o    (pick_valid),
        .next_ptr_o (pick_next)
    );

    // Reset and flush both suppress every handshake this cycle.
    assign live = ~rst & ~flush;

    always_comb begin
        grant_any = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            grant_any = grant_any | pick_grant[p*REQ_NUM +: REQ_NUM];
        end
    end

    assign req_ready = {REQ_NUM{live}} & grant_any;

    // One-hot AND-OR mux from requesters to each port.
    always_comb begin
        mux_id  = '0;
        mux_val = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int j = 0; j < REQ_NUM; j++) begin
                if (pick_grant[p*REQ_NUM + j]) begin
                    mux_id[p*IDW +: IDW] =
                        mux_id[p*IDW +: IDW] | req_phy_id[j*IDW +: IDW];
                    mux_val[p*DW +: DW] =
                        mux_val[p*DW +: DW] | req_value[j*DW +: DW];
                end
            end
        end
    end

    // Idle ports keep their last id/value; only the valid bit drops.
    always_comb begin
        port_valid_d = live ? pick_valid : '0;
        port_id_d    = port_id_q;
        port_val_d   = port_val_q;
        rr_ptr_d     = rr_ptr_q;
        for (int p = 0; p < PORT_NUM; p++) begin
            if (port_valid_d[p]) begin
                port_id_d[p*IDW +: IDW] = mux_id[p*IDW +: IDW];
                port_val_d[p*DW +: DW]  = mux_val[p*DW +: DW];
            end
        end
        if (live && (|pick_valid)) begin
            rr_ptr_d = pick_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            port_valid_q <= '0;
            port_id_q    <= '0;
            port_val_q   <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            port_valid_q <= port_valid_d;
            port_id_q    <= port_id_d;
            port_val_q   <= port_val_d;
        end
    end

    assign port_valid  = port_valid_q;
    assign port_phy_id = port_id_q;
    assign port_value  = port_val_q;

`ifdef EXECUTE_FEEDBACK_ARBITER_PERF_EN
    logic [31:0] grant_cnt_q, grant_cnt_d;
    logic [31:0] confl_cnt_q, confl_cnt_d;

    // req_ready is already zero under flush, so both counters freeze.
    always_comb begin
        grant_cnt_d = grant_cnt_q + 32'($countones(req_ready));
        confl_cnt_d = confl_cnt_q;
        if (live && (|(req_valid & ~req_ready))) begin
            confl_cnt_d = confl_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt_q <= '0;
            confl_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            confl_cnt_q <= confl_cnt_d;
        end
    end

    assign perf_grant_count    = grant_cnt_q;
    assign perf_conflict_count = confl_cnt_q;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_execute_feedback_arbiter.sv
// Self-checking bench for execute_feedback_arbiter: directed table,
// fairness run, optional perf sequence and randomized model comparison.
module tb_execute_feedback_arbiter;

    localparam int REQ = 8;
    localparam int PN  = 2;
    localparam int IDW = 6;
    localparam int DW  = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                flush;
    logic [REQ-1:0]      req_valid;
    logic [REQ*IDW-1:0]  req_phy_id;
    logic [REQ*DW-1:0]   req_value;
    logic [REQ-1:0]      req_ready;
    logic [PN-1:0]       port_valid;
    logic [PN*IDW-1:0]   port_phy_id;
    logic [PN*DW-1:0]    port_value;
`ifdef EXECUTE_FEEDBACK_ARBITER_PERF_EN
    logic [31:0]         perf_grant_count;
    logic [31:0]         perf_conflict_count;
`endif

    always #5 clk = ~clk;

    execute_feedback_arbiter #(
        .REQ_NUM          (REQ),
        .PORT_NUM         (PN),
        .PHY_REG_ID_WIDTH (IDW),
        .DATA_WIDTH       (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_phy_id  (req_phy_id),
        .req_value   (req_value),
        .req_ready   (req_ready),
        .port_valid  (port_valid),
        .port_phy_id (port_phy_id),
        .port_value  (port_value)
`ifdef EXECUTE_FEEDBACK_ARBITER_PERF_EN
        ,
        .perf_grant_count    (perf_grant_count),
        .perf_conflict_count (perf_conflict_count)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Requester-side stimulus state.
    logic [IDW-1:0] ids  [REQ];
    logic [DW-1:0]  vals [REQ];
    logic [REQ-1:0] pend;
    logic [IDW-1:0] hid  [REQ];
    logic [DW-1:0]  hval [REQ];
    logic [REQ-1:0] act_ready;

    // Reference model state.
    int             m_ptr;
    logic [PN-1:0]  m_pv;
    logic [IDW-1:0] m_id  [PN];
    logic [DW-1:0]  m_val [PN];
    logic [31:0]    m_gc;
    logic [31:0]    m_cc;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, check ready mid-cycle, advance the model,
    // check registered outputs just after the edge.
    task automatic cycle(input logic [REQ-1:0] v, input logic f,
                         input logic r);
        int q[$];
        logic [REQ-1:0] er;
        rst       = r;
        flush     = f;
        req_valid = v;
        for (int i = 0; i < REQ; i++) begin
            req_phy_id[i*IDW +: IDW] = ids[i];
            req_value[i*DW +: DW]    = vals[i];
            if (!r && pend[i]) begin
                assert (v[i] && ids[i] == hid[i] && vals[i] == hval[i])
                else $error("requester %0d released an untransferred result", i);
            end
        end
        @(negedge clk);
        er = '0;
        if (!r && !f) begin
            for (int k = 0; k < REQ; k++) begin
                int idx;
                idx = (m_ptr + k) % REQ;
                if (v[idx] && q.size() < PN) q.push_back(idx);
            end
            foreach (q[k]) er[q[k]] = 1'b1;
        end
        act_ready = req_ready;
        chk("req_ready", 64'(req_ready), 64'(er));
        if (r) begin
            m_ptr = 0;
            m_pv  = '0;
            m_gc  = '0;
            m_cc  = '0;
            for (int p = 0; p < PN; p++) begin
                m_id[p]  = '0;
                m_val[p] = '0;
            end
        end else begin
            m_pv = '0;
            foreach (q[k]) begin
                m_pv[k]  = 1'b1;
                m_id[k]  = ids[q[k]];
                m_val[k] = vals[q[k]];
            end
            if (q.size() > 0) m_ptr = (q[q.size()-1] + 1) % REQ;
            if (!f) begin
                m_gc = m_gc + 32'(q.size());
                if ((v & ~er) != '0) m_cc = m_cc + 32'd1;
            end
        end
        for (int i = 0; i < REQ; i++) begin
            pend[i] = !r && v[i] && !er[i];
            hid[i]  = ids[i];
            hval[i] = vals[i];
        end
        @(posedge clk);
        #1;
        chk("port_valid", 64'(port_valid), 64'(m_pv));
        for (int p = 0; p < PN; p++) begin
            chk($sformatf("port%0d_phy_id", p),
                64'(port_phy_id[p*IDW +: IDW]), 64'(m_id[p]));
            chk($sformatf("port%0d_value", p),
                64'(port_value[p*DW +: DW]), 64'(m_val[p]));
        end
        chk("rr_ptr", 64'(dut.rr_ptr_q), 64'(m_ptr));
`ifdef EXECUTE_FEEDBACK_ARBITER_PERF_EN
        chk("perf_grant", 64'(perf_grant_count), 64'(m_gc));
        chk("perf_conflict", 64'(perf_conflict_count), 64'(m_cc));
`endif
    endtask

    typedef struct {
        logic [REQ-1:0] valid;
        logic           flush;
        logic [REQ-1:0] ready;
        logic [PN-1:0]  pv;
        int             ptr;
    } vec_t;

    vec_t tbl [9];
    int   gcnt [REQ];
    int   gap  [REQ];

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        req_valid  = '0;
        req_phy_id = '0;
        req_value  = '0;
        pend       = '0;
        m_ptr      = 0;
        m_pv       = '0;
        m_gc       = '0;
        m_cc       = '0;
        for (int p = 0; p < PN; p++) begin
            m_id[p]  = '0;
            m_val[p] = '0;
        end
        for (int i = 0; i < REQ; i++) begin
            ids[i]  = IDW'(i * 7 + 1);
            vals[i] = DW'(32'hA000 + i);
            hid[i]  = '0;
            hval[i] = '0;
        end
        ids[0]  = 6'd3;
        vals[0] = 32'h11;
        ids[2]  = 6'd9;
        vals[2] = 32'h22;

        tbl[0] = '{8'h05, 1'b0, 8'h05, 2'b11, 3};
        tbl[1] = '{8'h20, 1'b0, 8'h20, 2'b01, 6};
        tbl[2] = '{8'hFF, 1'b0, 8'hC0, 2'b11, 0};
        tbl[3] = '{8'h3F, 1'b0, 8'h03, 2'b11, 2};
        tbl[4] = '{8'h3C, 1'b0, 8'h0C, 2'b11, 4};
        tbl[5] = '{8'h30, 1'b0, 8'h30, 2'b11, 6};
        tbl[6] = '{8'h06, 1'b1, 8'h00, 2'b00, 6};
        tbl[7] = '{8'h06, 1'b0, 8'h06, 2'b11, 3};
        tbl[8] = '{8'h00, 1'b0, 8'h00, 2'b00, 3};

        // Reset held two cycles with every requester asking.
        cycle(8'hFF, 1'b0, 1'b1);
        cycle(8'hFF, 1'b0, 1'b1);

        for (int t = 0; t < 9; t++) begin
            cycle(tbl[t].valid, tbl[t].flush, 1'b0);
            chk($sformatf("tbl%0d_ready", t), 64'(act_ready), 64'(tbl[t].ready));
            chk($sformatf("tbl%0d_pv", t), 64'(port_valid), 64'(tbl[t].pv));
            chk($sformatf("tbl%0d_ptr", t), 64'(dut.rr_ptr_q), 64'(tbl[t].ptr));
            if (t == 0) begin
                chk("basic_p0_id", 64'(port_phy_id[5:0]), 64'd3);
                chk("basic_p0_val", 64'(port_value[31:0]), 64'h11);
                chk("basic_p1_id", 64'(port_phy_id[11:6]), 64'd9);
                chk("basic_p1_val", 64'(port_value[63:32]), 64'h22);
            end
        end

        // Oversubscription: all eight valid for 64 cycles.
        for (int i = 0; i < REQ; i++) begin
            gcnt[i] = 0;
            gap[i]  = 0;
        end
        for (int c = 0; c < 64; c++) begin
            cycle(8'hFF, 1'b0, 1'b0);
            for (int i = 0; i < REQ; i++) begin
                gap[i]++;
                if (act_ready[i]) begin
                    gcnt[i]++;
                    if (gap[i] > 4) chk($sformatf("wait_req%0d", i), 64'(gap[i]), 64'd4);
                    gap[i] = 0;
                end
            end
        end
        for (int i = 0; i < REQ; i++) begin
            chk($sformatf("fair_req%0d", i), 64'(gcnt[i]), 64'd16);
            chk($sformatf("tail_wait_req%0d", i), 64'(gap[i] > 4), 64'd0);
        end

`ifdef EXECUTE_FEEDBACK_ARBITER_PERF_EN
        cycle(8'h00, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) cycle(8'h07, 1'b0, 1'b0);
        chk("perf_grant_5cyc", 64'(perf_grant_count), 64'd10);
        chk("perf_conflict_5cyc", 64'(perf_conflict_count), 64'd5);
`endif

        // Randomized traffic honoring the hold-until-transfer rule.
        for (int c = 0; c < 400; c++) begin
            logic [REQ-1:0] v;
            logic f;
            logic r;
            for (int i = 0; i < REQ; i++) begin
                if (pend[i]) begin
                    v[i] = 1'b1;
                end else begin
                    v[i]    = 1'($urandom_range(0, 1));
                    ids[i]  = IDW'($urandom);
                    vals[i] = $urandom;
                end
            end
            f = ($urandom_range(0, 15) == 0);
            r = ($urandom_range(0, 63) == 0);
            cycle(v, f, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
